seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount bits taken from B[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 ALUOp  input  3  000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra, 110 mulu, 111 divu.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 C  output  WIDTH  primary result (sum/diff/logic/shift, mul low half, quotient).
REQ-011 R  output  WIDTH  secondary result (mul high half, remainder), 0 for ops 000-101.
REQ-012 out_valid  output  1  C/R valid.
REQ-013 out_ready  input  1  consumer accepts result.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; exactly one active.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready on a clock edge; A, B and ALUOp captured then.
REQ-016 Ops 000-101: IDLE -> DONE on acceptance; result valid the next cycle (latency 1).
REQ-017 add/sub: modulo 2^WIDTH, carry/borrow discarded.
REQ-018 srl: logical right shift by B[SHW-1:0]; sra: arithmetic (sign-fill from A[WIDTH-1]); shift 0 returns A.
REQ-019 mulu: unsigned shift-add, one partial product per cycle; IDLE -> BUSY, WIDTH cycles in BUSY, then DONE; total latency WIDTH+1 edges from acceptance to out_valid; {R,C} = A*B (2*WIDTH bits).
REQ-020 divu: unsigned restoring division, one quotient bit per cycle, same timing as mulu; C = A/B, R = A%B.
REQ-021 divu with B==0: no BUSY phase, DONE after 1 cycle; C = all ones, R = A.
REQ-022 Iteration counter SHALL count WIDTH-1 down to 0; BUSY -> DONE when counter reaches 0.
REQ-023 out_valid = 1 exactly in DONE; C and R SHALL hold stable while out_valid && !out_ready.
REQ-024 DONE -> IDLE on out_ready; out_valid drops next cycle; a new request is acceptable no earlier than the cycle after (one bubble; no result/accept overlap).
REQ-025 A, B, ALUOp and in_valid are ignored while BUSY or DONE; changes there SHALL NOT affect the in-flight result.
REQ-026 out_ready while not DONE has no effect.
REQ-027 Undefined/X never driven on outputs after reset.

Reset
REQ-028 rst_n low SHALL immediately (without clock) force IDLE, in_ready=1 once released, out_valid=0, C=0, R=0, counter=0, internal operand registers cleared.
REQ-029 Reset asserted during BUSY or DONE aborts the operation; no result is ever presented for it.
REQ-030 First acceptance possible on the first rising edge with rst_n high.

Verification (WIDTH=32)
REQ-031 A=0x800000F1, B=4, ops 000..101 each with out_ready=1 -> C = 0x800000F5, 0x800000ED, 0x00000000, 0x800000F5, 0x0800000F, 0xF800000F; R=0; out_valid one cycle after each accept.
REQ-032 mulu A=0xFFFFFFFF, B=2 -> out_valid exactly 33 edges after accept, C=0xFFFFFFFE, R=0x00000001; in_ready=0 throughout.
REQ-033 divu A=100, B=7 -> C=14, R=2 at 33 edges; divu A=5, B=0 -> C=0xFFFFFFFF, R=5 after 1 edge.
REQ-034 Backpressure: mulu 7*6 with out_ready=0 for 5 cycles after out_valid -> C=42, R=0 held stable, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-divu (cycle 10 of BUSY) -> out_valid=0, C=R=0 immediately; following add 3+4 -> C=7 with latency 1.
REQ-036 Random regression: 10k mixed ops vs reference model, random in_valid/out_ready -> zero mismatches, no lost or duplicated results.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready request side and a valid/ready
// result side. Single-cycle ops (add, sub, and, or, srl, sra) complete one edge
// after acceptance. mulu (shift-add) and divu (restoring) take one bit per
// cycle for WIDTH cycles in BUSY, giving WIDTH+1 edges from acceptance to
// out_valid. divu by zero skips BUSY: C = all ones, R = A.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE, out_valid only in DONE, so there is always a one-cycle
// bubble between handing off a result and accepting the next request.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   A, B, ALUOp       operands and opcode, sampled on acceptance only
//   in_valid/in_ready request handshake
//   C, R, out_valid   primary/secondary result and its valid
//   out_ready         consumer accepts result
//   dbg_state_o       current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] R,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opnd_q;    // multiplicand (mulu) or divisor (divu)
  logic [WIDTH-1:0] c_q;       // mulu: low product / multiplier; divu: quotient / dividend
  logic [WIDTH-1:0] r_q;       // mulu: high product; divu: partial remainder
  logic [CW-1:0]    cnt_q;
  logic             op_div_q;

  // Single-cycle result straight from the request inputs.
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] quick_res;

  always_comb begin
    sh        = B[SHW-1:0];
    quick_res = '0;
    case (ALUOp)
      OP_ADD:  quick_res = A + B;
      OP_SUB:  quick_res = A - B;
      OP_AND:  quick_res = A & B;
      OP_OR:   quick_res = A | B;
      OP_SRL:  quick_res = A >> sh;
      OP_SRA:  quick_res = $signed(A) >>> sh;
      default: quick_res = '0;
    endcase
  end

  // One iteration of the multi-cycle datapath.
  // mulu: {r,c} holds the running product with the unconsumed multiplier bits
  //   in the low end of c; add the multiplicand when c[0] is set, shift right.
  // divu: shift the next dividend bit (c MSB) into the remainder, subtract the
  //   divisor when it fits, and shift the quotient bit into c's LSB.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_c_d;
  logic [WIDTH-1:0] step_r_d;

  always_comb begin
    mul_sum    = {1'b0, r_q} + (c_q[0] ? {1'b0, opnd_q} : '0);
    div_rem_sh = {r_q, c_q[WIDTH-1]};
    div_ge     = (div_rem_sh >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    div_sub    = div_rem_sh[WIDTH-1:0] - opnd_q;
    step_c_d   = '0;
    step_r_d   = '0;
    if (op_div_q) begin
      step_r_d = div_ge ? div_sub : div_rem_sh[WIDTH-1:0];
      step_c_d = {c_q[WIDTH-2:0], div_ge};
    end else begin
      step_r_d = mul_sum[WIDTH:1];
      step_c_d = {mul_sum[0], c_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opnd_q   <= '0;
      c_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            case (ALUOp)
              OP_MULU: begin
                opnd_q   <= A;
                c_q      <= B;
                r_q      <= '0;
                cnt_q    <= CW'(WIDTH - 1);
                op_div_q <= 1'b0;
                state_q  <= ST_BUSY;
              end
              OP_DIVU: begin
                if (B == '0) begin
                  c_q     <= '1;
                  r_q     <= A;
                  state_q <= ST_DONE;
                end else begin
                  opnd_q   <= B;
                  c_q      <= A;
                  r_q      <= '0;
                  cnt_q    <= CW'(WIDTH - 1);
                  op_div_q <= 1'b1;
                  state_q  <= ST_BUSY;
                end
              end
              default: begin
                c_q     <= quick_res;
                r_q     <= '0;
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_BUSY: begin
          c_q <= step_c_d;
          r_q <= step_r_d;
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign C           = c_q;
  assign R           = r_q;
  assign dbg_state_o = state_q;

endmodule
